// File: rtl/countdown_timer.sv
// ============================================================================
// Module   : countdown_timer
// Brief    : Loadable down-counting timer with start/pause/stop control,
//            prescaled tick, terminal-count pulse and optional auto-reload.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             reload_en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc_pulse
);

  localparam int c_PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_count;
  logic [WIDTH-1:0]   w_count_nxt;
  logic [c_PRE_W-1:0] r_prescale;
  logic [c_PRE_W-1:0] w_prescale_nxt;
  logic               r_tc;
  logic               w_tc_nxt;
  logic               w_tick;

  assign w_tick = (r_prescale == c_PRE_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_prescale <= '0;
      r_tc       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_prescale <= w_prescale_nxt;
      r_tc       <= w_tc_nxt;
    end
  end

  // Priority: stop > start > pause > tick.
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_prescale_nxt = r_prescale;
    w_tc_nxt       = 1'b0;
    if (stop) begin
      w_state_nxt    = ST_IDLE;
      w_count_nxt    = '0;
      w_prescale_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            w_state_nxt    = ST_RUN;
            w_count_nxt    = load_val;
            w_prescale_nxt = '0;
          end
        end
        ST_RUN: begin
          if (pause) begin
            w_state_nxt = ST_PAUSED;
          end else if (w_tick) begin
            w_prescale_nxt = '0;
            if (r_count != '0) begin
              w_count_nxt = r_count - WIDTH'(1);
            end else begin
              // Terminal event: reload and keep running, or park in DONE at 0.
              w_tc_nxt = 1'b1;
              if (reload_en) begin
                w_count_nxt = load_val;
              end else begin
                w_state_nxt = ST_DONE;
              end
            end
          end else begin
            w_prescale_nxt = r_prescale + c_PRE_W'(1);
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign count    = r_count;
  assign tc_pulse = r_tc;
  assign busy     = (r_state == ST_RUN) || (r_state == ST_PAUSED);
  assign done     = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// ============================================================================
// Module   : tb_countdown_timer
// Brief    : Scoreboard bench for countdown_timer at PRESCALE=1 and PRESCALE=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_countdown_timer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       pause;
  logic       reload_en;
  logic [3:0] load_val;

  logic [3:0] p1_count, p4_count;
  logic       p1_busy, p1_done, p1_tc;
  logic       p4_busy, p4_done, p4_tc;

  int n_checks;
  int n_fails;

  countdown_timer #(.WIDTH(4), .PRESCALE(1)) u_p1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .reload_en(reload_en), .load_val(load_val),
    .count(p1_count), .busy(p1_busy), .done(p1_done), .tc_pulse(p1_tc)
  );

  countdown_timer #(.WIDTH(4), .PRESCALE(4)) u_p4 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .reload_en(reload_en), .load_val(load_val),
    .count(p4_count), .busy(p4_busy), .done(p4_done), .tc_pulse(p4_tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: st 0=IDLE 1=RUN 2=PAUSED 3=DONE.
  typedef struct {
    int st;
    int cnt;
    int pre;
    bit tc;
  } mdl_t;

  typedef struct packed {
    logic [3:0] c1;
    logic       b1, d1, t1;
    logic [3:0] c4;
    logic       b4, d4, t4;
  } exp_t;

  mdl_t m1, m4;
  exp_t exp_q[$];

  function automatic mdl_t mdl_step(mdl_t m, int ps, bit st_i, bit sp_i, bit pa_i,
                                    bit rl_i, int lv);
    mdl_t n;
    n    = m;
    n.tc = 1'b0;
    if (sp_i) begin
      n.st = 0; n.cnt = 0; n.pre = 0;
    end else if ((m.st == 0 || m.st == 3) && st_i) begin
      n.st = 1; n.cnt = lv; n.pre = 0;
    end else if (m.st == 1) begin
      if (pa_i) begin
        n.st = 2;
      end else if (m.pre == ps - 1) begin
        n.pre = 0;
        if (m.cnt != 0) begin
          n.cnt = m.cnt - 1;
        end else begin
          n.tc = 1'b1;
          if (rl_i) n.cnt = lv;
          else      n.st = 3;
        end
      end else begin
        n.pre = m.pre + 1;
      end
    end else if (m.st == 2 && !pa_i) begin
      n.st = 1;
    end
    return n;
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t n;
    n.st = 0; n.cnt = 0; n.pre = 0; n.tc = 1'b0;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: model both DUTs at the edge, push expectation, pop and compare at negedge.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    m1 = mdl_step(m1, 1, start, stop, pause, reload_en, int'(load_val));
    m4 = mdl_step(m4, 4, start, stop, pause, reload_en, int'(load_val));
    e.c1 = 4'(m1.cnt); e.b1 = (m1.st == 1 || m1.st == 2); e.d1 = (m1.st == 3); e.t1 = m1.tc;
    e.c4 = 4'(m4.cnt); e.b4 = (m4.st == 1 || m4.st == 2); e.d4 = (m4.st == 3); e.t4 = m4.tc;
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("p1_count", 32'(p1_count), 32'(e.c1));
      check("p1_busy",  32'(p1_busy),  32'(e.b1));
      check("p1_done",  32'(p1_done),  32'(e.d1));
      check("p1_tc",    32'(p1_tc),    32'(e.t1));
      check("p4_count", 32'(p4_count), 32'(e.c4));
      check("p4_busy",  32'(p4_busy),  32'(e.b4));
      check("p4_done",  32'(p4_done),  32'(e.d4));
      check("p4_tc",    32'(p4_tc),    32'(e.t4));
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic stop_all();
    stop = 1'b1; start = 1'b0; pause = 1'b0; reload_en = 1'b0;
    cycle();
    stop = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fails = 0;
    m1 = mdl_reset(); m4 = mdl_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    reload_en = 1'b0; load_val = 4'd0;
    @(negedge clk); @(negedge clk);
    check("rst_count", 32'(p1_count), 32'd0);
    check("rst_busy",  32'(p1_busy),  32'd0);
    check("rst_done",  32'(p1_done),  32'd0);
    check("rst_tc",    32'(p1_tc),    32'd0);
    reset = 1'b0;
    run(2);

    // One-shot, load 3: counts 3,2,1,0 then tc+done on the 5th edge.
    load_val = 4'd3; start = 1'b1;
    cycle();
    start = 1'b0;
    check("os_k0", 32'(p1_count), 32'd3);
    for (int k = 1; k <= 3; k++) begin
      cycle();
      check("os_cnt", 32'(p1_count), 32'(3 - k));
      check("os_notc", 32'(p1_tc), 32'd0);
    end
    cycle();
    check("os_tc",   32'(p1_tc),   32'd1);
    check("os_done", 32'(p1_done), 32'd1);
    check("os_busy", 32'(p1_busy), 32'd0);
    cycle();
    check("os_tc_one", 32'(p1_tc), 32'd0);
    run(12);

    // Auto-reload, load 2: 2,1,0,2,1,0 with tc on each reload.
    load_val = 4'd2; reload_en = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    check("ar_k0", 32'(p1_count), 32'd2);
    for (int k = 1; k <= 6; k++) begin
      cycle();
      check("ar_cnt",  32'(p1_count), 32'(2 - (k % 3)));
      check("ar_tc",   32'(p1_tc),    32'((k % 3) == 0));
      check("ar_busy", 32'(p1_busy),  32'd1);
    end
    stop_all();

    // Prescale 4, load 1: tc 8 cycles after the start edge.
    load_val = 4'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      check("ps_cnt", 32'(p4_count), (k < 4) ? 32'd1 : 32'd0);
      check("ps_tc",  32'(p4_tc),    32'(k == 8));
    end
    run(2);

    // Pause while count=3, then stop+start together.
    load_val = 4'd5; start = 1'b1;
    cycle();
    start = 1'b0;
    run(2);
    check("pa_pre", 32'(p1_count), 32'd3);
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("pa_hold", 32'(p1_count), 32'd3);
      check("pa_busy", 32'(p1_busy),  32'd1);
    end
    pause = 1'b0;
    cycle();
    cycle();
    check("pa_resume", 32'(p1_count), 32'd2);
    stop = 1'b1; start = 1'b1;
    cycle();
    stop = 1'b0; start = 1'b0;
    check("ss_count", 32'(p1_count), 32'd0);
    check("ss_busy",  32'(p1_busy),  32'd0);
    check("ss_tc",    32'(p1_tc),    32'd0);
    run(2);

    // load 0 terminates on the first tick.
    load_val = 4'd0; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    check("z_tc",   32'(p1_tc),   32'd1);
    check("z_done", 32'(p1_done), 32'd1);
    run(6);

    // start during RUN is ignored; load_val change only matters on next load.
    load_val = 4'd5; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    load_val = 4'd9; start = 1'b1;
    cycle();
    start = 1'b0;
    check("sr_ign", 32'(p1_count), 32'd3);
    cycle();
    check("sr_cont", 32'(p1_count), 32'd2);
    stop_all();

    // load 15: 16 ticks to terminal.
    load_val = 4'd15; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      cycle();
      check("f_tc", 32'(p1_tc), 32'(k == 16));
    end
    stop_all();

    // Async reset mid-run with count=9.
    load_val = 4'd9; start = 1'b1;
    cycle();
    start = 1'b0;
    check("ra_pre", 32'(p1_count), 32'd9);
    #2;
    reset = 1'b1;
    #1;
    check("ra_count", 32'(p1_count), 32'd0);
    check("ra_busy",  32'(p1_busy),  32'd0);
    check("ra_done",  32'(p1_done),  32'd0);
    check("ra_tc",    32'(p1_tc),    32'd0);
    m1 = mdl_reset(); m4 = mdl_reset();
    @(negedge clk);
    reset = 1'b0;
    run(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
